if_fetch: RTL
=============

Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the instruction cache.
- Owns the PC and drives cache lookups. On a hit it hands the instruction to IF/ID; on a miss it refills the cache line byte-by-byte from the memory arbiter (8-bit bus), then re-looks-up.
- Handles branch/jump redirects from EX and back-pressure stalls from downstream.

Parameters:
- INDEX_W, 8, cache index width; selects pc[INDEX_W+1:2].
- TAG_W, 8, cache tag width; selects pc[INDEX_W+TAG_W+1:INDEX_W+2].
- RESET_PC, 32'h0, PC value loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall_i  in  1  downstream cannot accept; hold outputs and PC
- jump_en  in  1  redirect request (one-cycle pulse)
- jump_addr  in  32  redirect target, word aligned
- cache_index  out  INDEX_W  lookup index, combinational from pc
- cache_tag  out  TAG_W  lookup tag, combinational from pc
- cache_hit  in  1  cache hit for current index/tag (combinational)
- cache_data  in  32  cached word
- cache_we  out  1  cache write strobe
- cache_w_index  out  INDEX_W  write index
- cache_w_tag  out  TAG_W  write tag
- cache_w_data  out  32  refilled word
- mem_req  out  1  byte read request
- mem_addr  out  32  byte address
- mem_ack  in  1  byte returned this cycle on mem_rdata
- mem_rdata  in  8  returned byte
- inst_valid  out  1  inst/inst_pc valid to IF/ID
- inst  out  32  instruction word
- inst_pc  out  32  address of inst

Behaviour:
- Reset (rst synchronous, active-high; clock clk):
  - pc=RESET_PC, state=LOOKUP, byte_cnt=0.
  - inst_valid=0, inst=0, inst_pc=0.
  - mem_req=0, mem_addr=0, cache_we=0, cache_w_*=0.
  - rst mid-refill abandons the refill; no cache write.
- States: LOOKUP, REFILL, WRITE.
- LOOKUP:
  - cache_hit=1 and !stall_i: at the edge, inst<=cache_data, inst_pc<=pc, inst_valid<=1, pc<=pc+4. One instruction per cycle on consecutive hits.
  - cache_hit=1 and stall_i: hold everything.
  - cache_hit=0: go to REFILL with byte_cnt=0. If !stall_i, inst_valid<=0.
- REFILL:
  - mem_req=1, mem_addr={pc[31:2],2'b00}+byte_cnt; both are registered outputs.
  - On mem_ack: store mem_rdata into byte lane byte_cnt (little-endian, byte 0 -> bits 7:0) and increment byte_cnt.
  - On the 4th ack: mem_req<=0, go to WRITE.
  - While mem_ack=0, mem_req and mem_addr are held.
- WRITE (exactly 1 cycle):
  - cache_we=1, cache_w_index/cache_w_tag taken from pc, cache_w_data = assembled word. Return to LOOKUP.
  - The next LOOKUP hits.
  - Miss penalty from the miss-detecting LOOKUP to inst_valid: 4 ack cycles + WRITE + 1 LOOKUP edge.
- inst_valid / stall_i:
  - When !stall_i and no hit is delivered, inst_valid<=0.
  - When stall_i, inst/inst_pc/inst_valid hold.
- jump_en (highest priority, any state, ignores stall_i), at the edge:
  - pc<=jump_addr, state<=LOOKUP, byte_cnt<=0, inst_valid<=0.
  - mem_req<=0, cache_we<=0.
  - A mem_ack in the same cycle is discarded.
  - A refill in progress is abandoned; the partial line is never written.
  - jump in the WRITE cycle: the write is suppressed.
- pc wraps modulo 2^32; addresses above the tag+index range alias by design.
- Output invariants:
  - mem_req is never high outside REFILL.
  - cache_we is never high outside WRITE.

Test Plan:
- Reset with RESET_PC=0, cache pre-loaded index 0..3 hit -> inst_valid rises 1 cycle after rst drops; inst_pc = 0,4,8,12 on consecutive cycles.
- Miss at pc=0x100, mem model acks every cycle with bytes 13,00,A0,00 at 0x100..0x103 -> mem_addr 0x100..0x103 in order; cache_we pulse with w_index=0x40, w_data=0x00A00013; inst=0x00A00013, inst_pc=0x100.
- Refill with mem_ack gaps (ack on alternate cycles) -> mem_addr held between acks, same assembled word, exactly 4 bytes consumed.
- stall_i high 3 cycles during hit stream at inst_pc=0x8 -> inst/inst_pc/inst_valid and pc frozen; resumes with inst_pc=0xC.
- jump_en to 0x200 after 2 refill bytes at 0x100 -> mem_req drops next cycle, no cache_we, next lookup at index 0x80, no instruction from 0x100 delivered.
- jump_en coincident with WRITE cycle and with stall_i=1 -> cache_we low, inst_valid 0 next cycle, pc=jump_addr.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage sitting in front of the instruction cache.
// Owns the PC and looks it up in the cache every cycle. A hit hands the
// word to IF/ID. A miss refills the line one byte at a time over the 8-bit
// memory arbiter bus, writes the assembled word into the cache, and then
// looks the PC up again. An EX redirect (jump_en) overrides everything.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall_i           downstream busy: hold inst outputs and PC
//   jump_en/addr      one-cycle redirect from EX (word aligned target)
//   cache_index/tag   lookup address, combinational from pc
//   cache_hit/data    cache lookup result (combinational)
//   cache_we/w_*      cache write port, active in the WRITE cycle only
//   mem_req/addr      registered byte read request to the arbiter
//   mem_ack/rdata     byte returned this cycle
//   inst_valid/inst/inst_pc   fetched instruction to IF/ID
//
// state  | meaning
// LOOKUP | present pc to cache; deliver on hit, start refill on miss
// REFILL | fetch 4 bytes of the missing word, lowest address first
// WRITE  | one cycle of cache_we with the assembled word

module if_fetch #(
   parameter int          INDEX_W  = 8,
   parameter int          TAG_W    = 8,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall_i,
   input  logic               jump_en,
   input  logic [31:0]        jump_addr,
   output logic [INDEX_W-1:0] cache_index,
   output logic [TAG_W-1:0]   cache_tag,
   input  logic               cache_hit,
   input  logic [31:0]        cache_data,
   output logic               cache_we,
   output logic [INDEX_W-1:0] cache_w_index,
   output logic [TAG_W-1:0]   cache_w_tag,
   output logic [31:0]        cache_w_data,
   output logic               mem_req,
   output logic [31:0]        mem_addr,
   input  logic               mem_ack,
   input  logic [7:0]         mem_rdata,
   output logic               inst_valid,
   output logic [31:0]        inst,
   output logic [31:0]        inst_pc
);

   typedef enum logic [1:0] {
      S_LOOKUP = 2'd0,
      S_REFILL = 2'd1,
      S_WRITE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [1:0]         byte_cnt_q, byte_cnt_d;
   logic [31:0]        line_q, line_d;
   logic               mem_req_q, mem_req_d;
   logic [31:0]        mem_addr_q, mem_addr_d;
   logic               cache_we_q, cache_we_d;
   logic [INDEX_W-1:0] cache_w_index_q, cache_w_index_d;
   logic [TAG_W-1:0]   cache_w_tag_q, cache_w_tag_d;
   logic [31:0]        cache_w_data_q, cache_w_data_d;
   logic               inst_valid_q, inst_valid_d;
   logic [31:0]        inst_q, inst_d;
   logic [31:0]        inst_pc_q, inst_pc_d;

   assign cache_index   = pc_q[INDEX_W+1:2];
   assign cache_tag     = pc_q[INDEX_W+TAG_W+1:INDEX_W+2];
   assign mem_req       = mem_req_q;
   assign mem_addr      = mem_addr_q;
   // A redirect arriving during WRITE must stop the strobe in that same
   // cycle, otherwise the line would land in the cache anyway.
   assign cache_we      = cache_we_q & ~jump_en;
   assign cache_w_index = cache_w_index_q;
   assign cache_w_tag   = cache_w_tag_q;
   assign cache_w_data  = cache_w_data_q;
   assign inst_valid    = inst_valid_q;
   assign inst          = inst_q;
   assign inst_pc       = inst_pc_q;

   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      byte_cnt_d      = byte_cnt_q;
      line_d          = line_q;
      mem_req_d       = mem_req_q;
      mem_addr_d      = mem_addr_q;
      cache_we_d      = 1'b0;
      cache_w_index_d = cache_w_index_q;
      cache_w_tag_d   = cache_w_tag_q;
      cache_w_data_d  = cache_w_data_q;
      inst_valid_d    = inst_valid_q;
      inst_d          = inst_q;
      inst_pc_d       = inst_pc_q;

      if (jump_en) begin
         pc_d         = jump_addr;
         state_d      = S_LOOKUP;
         byte_cnt_d   = 2'd0;
         inst_valid_d = 1'b0;
         mem_req_d    = 1'b0;
      end else begin
         case (state_q)
            S_LOOKUP: begin
               if (cache_hit) begin
                  if (!stall_i) begin
                     inst_d       = cache_data;
                     inst_pc_d    = pc_q;
                     inst_valid_d = 1'b1;
                     pc_d         = pc_q + 32'd4;
                  end
               end else begin
                  state_d    = S_REFILL;
                  byte_cnt_d = 2'd0;
                  mem_req_d  = 1'b1;
                  mem_addr_d = {pc_q[31:2], 2'b00};
                  if (!stall_i) inst_valid_d = 1'b0;
               end
            end
            S_REFILL: begin
               if (!stall_i) inst_valid_d = 1'b0;
               if (mem_ack) begin
                  line_d[{byte_cnt_q, 3'b000} +: 8] = mem_rdata;
                  if (byte_cnt_q == 2'd3) begin
                     mem_req_d       = 1'b0;
                     state_d         = S_WRITE;
                     byte_cnt_d      = 2'd0;
                     cache_we_d      = 1'b1;
                     cache_w_index_d = pc_q[INDEX_W+1:2];
                     cache_w_tag_d   = pc_q[INDEX_W+TAG_W+1:INDEX_W+2];
                     cache_w_data_d  = line_d;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 2'd1;
                     mem_addr_d = {pc_q[31:2], byte_cnt_q + 2'd1};
                  end
               end
            end
            S_WRITE: begin
               if (!stall_i) inst_valid_d = 1'b0;
               state_d = S_LOOKUP;
            end
            default: begin
               state_d = S_LOOKUP;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_LOOKUP;
         pc_q            <= RESET_PC;
         byte_cnt_q      <= 2'd0;
         line_q          <= 32'd0;
         mem_req_q       <= 1'b0;
         mem_addr_q      <= 32'd0;
         cache_we_q      <= 1'b0;
         cache_w_index_q <= '0;
         cache_w_tag_q   <= '0;
         cache_w_data_q  <= 32'd0;
         inst_valid_q    <= 1'b0;
         inst_q          <= 32'd0;
         inst_pc_q       <= 32'd0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         byte_cnt_q      <= byte_cnt_d;
         line_q          <= line_d;
         mem_req_q       <= mem_req_d;
         mem_addr_q      <= mem_addr_d;
         cache_we_q      <= cache_we_d;
         cache_w_index_q <= cache_w_index_d;
         cache_w_tag_q   <= cache_w_tag_d;
         cache_w_data_q  <= cache_w_data_d;
         inst_valid_q    <= inst_valid_d;
         inst_q          <= inst_d;
         inst_pc_q       <= inst_pc_d;
      end
   end

endmodule
